// File: rtl/cmult_share_arb.sv
// Round-robin shared 3-stage complex multiplier with a single tagged result bus.
// Optional feature: define CMULT_ARB_CONJ_EN to add req_conj, which selects A*conj(B) per request.
module cmult_share_arb #(
    parameter int NREQ = 4,
    parameter int W1   = 14,
    parameter int W2   = 14,
    parameter int IDW  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*W1-1:0]         req_re1,
    input  logic [NREQ*W1-1:0]         req_im1,
    input  logic [NREQ*W2-1:0]         req_re2,
    input  logic [NREQ*W2-1:0]         req_im2,
`ifdef CMULT_ARB_CONJ_EN
    input  logic [NREQ-1:0]            req_conj,
`endif
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [IDW-1:0]             res_id,
    output logic signed [W1+W2:0]      res_re,
    output logic signed [W1+W2:0]      res_im,
    output logic                       busy
);
    localparam int PW = W1 + W2;
    localparam int OW = PW + 1;

    logic                 advance;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic                 gnt_any;
    logic [IDW-1:0]       gnt_id;
    logic [W1-1:0]        g_re1, g_im1;
    logic [W2-1:0]        g_re2, g_im2;
    logic                 g_conj;
    int                   idx;

    logic                 s1_v_q, s2_v_q, s3_v_q;
    logic [IDW-1:0]       s1_id_q, s2_id_q, s3_id_q;
    logic                 s1_conj_q, s2_conj_q;
    logic [W1-1:0]        s1_re1_q, s1_im1_q;
    logic [W2-1:0]        s1_re2_q, s1_im2_q;

    logic signed [PW-1:0] a_re, a_im, b_re, b_im;
    logic signed [PW-1:0] p_rr_d, p_ii_d, p_ri_d, p_ir_d;
    logic signed [PW-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;
    logic signed [OW-1:0] e_rr, e_ii, e_ri, e_ir;
    logic signed [OW-1:0] res_re_d, res_im_d, res_re_q, res_im_q;

    assign advance = !s3_v_q || res_ready;

    // Grant depends only on req_valid, the pointer and advance, never on operand data.
    always_comb begin
        gnt_any   = 1'b0;
        gnt_id    = '0;
        g_re1     = '0;
        g_im1     = '0;
        g_re2     = '0;
        g_im2     = '0;
        g_conj    = 1'b0;
        req_ready = '0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!gnt_any && req_valid[idx] && advance && rst_n) begin
                gnt_any        = 1'b1;
                gnt_id         = IDW'(idx);
                g_re1          = req_re1[idx*W1 +: W1];
                g_im1          = req_im1[idx*W1 +: W1];
                g_re2          = req_re2[idx*W2 +: W2];
                g_im2          = req_im2[idx*W2 +: W2];
`ifdef CMULT_ARB_CONJ_EN
                g_conj         = req_conj[idx];
`endif
                req_ready[idx] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
        end
    end

    // Operands are sign-extended to the product width so each product is exact.
    assign a_re   = {{W2{s1_re1_q[W1-1]}}, s1_re1_q};
    assign a_im   = {{W2{s1_im1_q[W1-1]}}, s1_im1_q};
    assign b_re   = {{W1{s1_re2_q[W2-1]}}, s1_re2_q};
    assign b_im   = {{W1{s1_im2_q[W2-1]}}, s1_im2_q};
    assign p_rr_d = a_re * b_re;
    assign p_ii_d = a_im * b_im;
    assign p_ri_d = a_re * b_im;
    assign p_ir_d = a_im * b_re;

    assign e_rr     = {p_rr_q[PW-1], p_rr_q};
    assign e_ii     = {p_ii_q[PW-1], p_ii_q};
    assign e_ri     = {p_ri_q[PW-1], p_ri_q};
    assign e_ir     = {p_ir_q[PW-1], p_ir_q};
    assign res_re_d = s2_conj_q ? (e_rr + e_ii) : (e_rr - e_ii);
    assign res_im_d = s2_conj_q ? (e_ir - e_ri) : (e_ri + e_ir);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            s1_v_q    <= 1'b0;
            s2_v_q    <= 1'b0;
            s3_v_q    <= 1'b0;
            s1_id_q   <= '0;
            s2_id_q   <= '0;
            s3_id_q   <= '0;
            s1_conj_q <= 1'b0;
            s2_conj_q <= 1'b0;
            s1_re1_q  <= '0;
            s1_im1_q  <= '0;
            s1_re2_q  <= '0;
            s1_im2_q  <= '0;
            p_rr_q    <= '0;
            p_ii_q    <= '0;
            p_ri_q    <= '0;
            p_ir_q    <= '0;
            res_re_q  <= '0;
            res_im_q  <= '0;
        end else if (advance) begin
            ptr_q  <= ptr_d;
            s1_v_q <= gnt_any;
            s2_v_q <= s1_v_q;
            s3_v_q <= s2_v_q;
            if (gnt_any) begin
                s1_id_q   <= gnt_id;
                s1_conj_q <= g_conj;
                s1_re1_q  <= g_re1;
                s1_im1_q  <= g_im1;
                s1_re2_q  <= g_re2;
                s1_im2_q  <= g_im2;
            end
            if (s1_v_q) begin
                s2_id_q   <= s1_id_q;
                s2_conj_q <= s1_conj_q;
                p_rr_q    <= p_rr_d;
                p_ii_q    <= p_ii_d;
                p_ri_q    <= p_ri_d;
                p_ir_q    <= p_ir_d;
            end
            if (s2_v_q) begin
                s3_id_q  <= s2_id_q;
                res_re_q <= res_re_d;
                res_im_q <= res_im_d;
            end
        end
    end

    assign res_valid = s3_v_q;
    assign res_id    = s3_id_q;
    assign res_re    = res_re_q;
    assign res_im    = res_im_q;
    assign busy      = s1_v_q || s2_v_q || s3_v_q;

endmodule
